// File: rtl/multi_lane_read_buffer_pkg.sv
// Shared definitions for the multi-lane read buffer: FSM encoding and LANES legality.
package multi_lane_read_buffer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  // Bit n set means LANES == n is supported.
  localparam logic [7:0] LEGAL_LANES_MASK = 8'b0001_0110;

  function automatic bit lanes_legal(input int lanes);
    return (lanes >= 1) && (lanes <= 7) && LEGAL_LANES_MASK[lanes[2:0]];
  endfunction

endpackage

// File: rtl/multi_lane_read_buffer.sv
// Captures read_count bits from LANES serial lines, one LANES-bit slice per read_sig strobe,
// and publishes the right-aligned word on data_out only when the capture completes.
module multi_lane_read_buffer
  import multi_lane_read_buffer_pkg::*;
#(
  parameter int BUF_SIZE  = 8,
  parameter int LANES     = 1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                            sys_clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            read_sig,
  input  logic [LANES-1:0]                in_lines,
  input  logic [$clog2(BUF_SIZE+1)-1:0]   read_count,
  output logic [BUF_SIZE-1:0]             data_out,
  output logic                            done_sig,
  output logic [$clog2(BUF_SIZE+1)-1:0]   bit_count,
  output logic                            err_sig
);

  localparam int CW = $clog2(BUF_SIZE + 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(BUF_SIZE);
  localparam logic [CW-1:0] LANE_STEP = CW'(LANES);

  generate
    if (!lanes_legal(LANES) || (BUF_SIZE < LANES)) begin : g_bad_params
      $error("multi_lane_read_buffer: LANES must be 1, 2 or 4 and must not exceed BUF_SIZE");
    end
  endgenerate

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       bit_count_q, bit_count_d;
  logic [BUF_SIZE-1:0] shift_q, shift_d;
  logic [BUF_SIZE-1:0] data_q, data_d;
  logic                err_q, err_d;

  logic [BUF_SIZE-1:0] lane_word;
  logic [BUF_SIZE-1:0] shift_next;
  logic [CW-1:0]       bits_next;
  logic                count_ok;

  // A strobe's lanes form one LANES-bit slice with in_lines[k] at relative weight k.
  assign lane_word = BUF_SIZE'(in_lines);
  assign bits_next = bit_count_q + LANE_STEP;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign shift_next = shift_q | (lane_word << bit_count_q);
    end else begin : g_msb_first
      assign shift_next = (shift_q << LANES) | lane_word;
    end
  endgenerate

  assign count_ok = (read_count != '0)
                 && (read_count <= MAX_COUNT)
                 && ((read_count % LANE_STEP) == '0);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    bit_count_d = bit_count_q;
    shift_d     = shift_q;
    data_d      = data_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_ok) begin
            count_d     = read_count;
            bit_count_d = '0;
            shift_d     = '0;
            err_d       = 1'b0;
            state_d     = READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      READ: begin
        // Abort takes priority even over the strobe that would complete the word.
        if (abort) begin
          state_d = IDLE;
        end else if (read_sig) begin
          shift_d     = shift_next;
          bit_count_d = bits_next;
          if (bits_next == count_q) begin
            data_d  = shift_next;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  assign data_out  = data_q;
  assign done_sig  = (state_q == IDLE);
  assign bit_count = bit_count_q;
  assign err_sig   = err_q;

endmodule

// File: doc/multi_lane_read_buffer.md
MULTI_LANE_READ_BUFFER -- requirements
Module: multi_lane_read_buffer

Interface
REQ-001 Parameter BUF_SIZE, default 8, SHALL set the maximum word length in bits and the data_out width.
REQ-002 Parameter LANES, default 1, legal values 1/2/4, SHALL set the number of serial input lines sampled per read_sig.
REQ-003 Parameter LSB_FIRST, default 0, SHALL select bit order: 0 = MSB first, 1 = LSB first.
REQ-004 sys_clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to begin a capture of read_count bits.
REQ-007 abort  in  1  one-cycle request to cancel an active capture.
REQ-008 read_sig  in  1  one-cycle, sys_clk-synchronous sample strobe from an external edge detector.
REQ-009 in_lines  in  LANES  serial data lines; in_lines[0] carries the earliest bit of each strobe.
REQ-010 read_count  in  $clog2(BUF_SIZE+1)  number of bits to capture; sampled only on an accepted start.
REQ-011 data_out  out  BUF_SIZE  captured word, right-aligned, unused upper bits zero.
REQ-012 done_sig  out  1  high while idle or ready, low while capturing.
REQ-013 bit_count  out  $clog2(BUF_SIZE+1)  bits captured so far in the current or last capture.
REQ-014 err_sig  out  1  sticky error flag, cleared by the next accepted start.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and READ.
REQ-016 In IDLE, start with read_count valid (nonzero, <= BUF_SIZE, a multiple of LANES) SHALL latch the count, clear bit_count and err_sig, and enter READ on the next edge.
REQ-017 In IDLE, start with an invalid read_count SHALL set err_sig, stay in IDLE, and leave data_out and done_sig unchanged.
REQ-018 In READ, each read_sig SHALL capture all LANES bits and add LANES to bit_count.
REQ-019 Bit order, MSB first: the first captured bit SHALL land at data_out index read_count-1.
REQ-020 Bit order, LSB first: the first captured bit SHALL land at index 0; within a strobe, lanes SHALL be ordered in_lines[0] then in_lines[LANES-1].
REQ-021 Completion: the edge that samples the read_sig bringing bit_count to read_count SHALL update data_out and return to IDLE, so done_sig is high one cycle after that read_sig.
REQ-022 data_out SHALL change only on completion and SHALL hold until the next completion.
REQ-023 read_sig in IDLE SHALL be ignored; start in READ SHALL be ignored.
REQ-024 start and read_sig in the same IDLE cycle: start SHALL be accepted and read_sig ignored.
REQ-025 abort in READ SHALL return to IDLE next edge, keep data_out, and leave err_sig clear; abort in IDLE SHALL have no effect.
REQ-026 abort coinciding with the final read_sig SHALL win: no data_out update.
REQ-027 Partial shift data SHALL live in an internal register that is never visible on data_out.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, data_out=0, bit_count=0, err_sig=0, done_sig=1, and clear the internal shift register, including mid-capture.
REQ-029 The first edge after rst deasserts SHALL accept a start.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE, READ) and the legal-LANES check constant.
REQ-031 Invalid LANES or BUF_SIZE < LANES SHALL be rejected at elaboration.
REQ-032 No sub-module is required; the sample strobe SHALL come from the existing edge-detector primitive outside this block.

Verification
REQ-033 BUF_SIZE=8, LANES=1, MSB first; capture 8 bits of 0x3A -> data_out=0x3A, done_sig high one cycle after the 8th read_sig.
REQ-034 LANES=1, LSB first, read_count=6; bits 1,0,1,0,1,0 -> data_out=0x15, bit_count=6.
REQ-035 LANES=4, MSB first, read_count=8; strobes 0x3 then 0xA on in_lines -> data_out=0x3A after 2 read_sig.
REQ-036 Reset asserted asynchronously after 3 of 6 bits -> done_sig=1 and data_out=0 immediately; a following 4-bit capture of 0xF -> data_out=0x0F.
REQ-037 read_count=0, then read_count=9, then read_count=3 with LANES=2 -> err_sig=1, state stays IDLE, data_out unchanged each time.
REQ-038 abort on the same cycle as the final read_sig of a 0x55 capture over a previous 0x3A -> data_out stays 0x3A, err_sig=0.
